kda_dispatch: RTL
=================

Name: kda_dispatch

Overview:
- Parametrised job dispatcher and collector for the KDA top level.
- Accepts one key-derivation job descriptor and fans it out to 1..NUM_CORES PBKDF2 cores; core k always computes PBKDF2 block k+1.
- Issues to each selected core on that core's own ready, and collects results in any completion order.
- Streams the concatenated derived key out in DATA_W beats with a last flag.
- Successor to the fixed 4-core, OR-of-readies control in the current top; independent per-core handshakes and framed output are new.

Parameters:
- NUM_CORES, 4, number of attached PBKDF2 cores; 1..8.
- HASH_W, 256, result width per core in bits; multiple of DATA_W.
- DATA_W, 64, output stream beat width in bits.
- CW, $clog2(NUM_CORES) (min 1), width of the job chunk field.

Ports:
- clk_i  in  1  clock.
- reset_ni  in  1  asynchronous active-low reset.
- job_chunks_i  in  CW  number of cores to use, minus 1.
- job_v_i  in  1  job descriptor valid.
- job_ready_o  out  1  dispatcher idle, can accept a job.
- core_v_o  out  NUM_CORES  per-core start request.
- core_ready_i  in  NUM_CORES  per-core start accepted.
- core_v_i  in  NUM_CORES  per-core result valid.
- core_hash_i  in  NUM_CORES*HASH_W  results; core k at [k*HASH_W +: HASH_W].
- core_yumi_o  out  NUM_CORES  per-core result consumed.
- data_o  out  DATA_W  output beat.
- v_o  out  1  output beat valid.
- last_o  out  1  final beat of job.
- yumi_i  in  1  consumer takes beat this cycle.
- busy_o  out  1  job in progress.

Behaviour:
- Reset:
  - Asynchronous assert, synchronous deassert handled upstream. While reset_ni=0, state=IDLE and all registers clear.
  - Every output is 0 during reset, including job_ready_o. job_ready_o=1 from the first clock edge after deassertion.
  - Reset mid-job aborts it. No beats are emitted afterwards, and the hash buffer contents are don't-care.
- States: IDLE, ISSUE, WAIT, SEND. busy_o = (state != IDLE).
- IDLE:
  - job_ready_o=1.
  - On job_v_i at edge t: latch N = job_chunks_i+1 (values above NUM_CORES-1 saturate to NUM_CORES), set mask = low N bits, clear the issued and captured bit vectors, go to ISSUE.
  - core_v_o goes high at t+1.
- ISSUE:
  - core_v_o[k] = mask[k] & ~issued[k]. issued[k] sets on core_v_o[k] & core_ready_i[k].
  - Cores accept independently in any cycle order.
  - When (issued | newly issued) == mask, go to WAIT.
- Capture (ISSUE and WAIT):
  - core_yumi_o[k] = core_v_i[k] & mask[k] & issued[k] & ~captured[k], which is combinational from core_v_i.
  - On yumi, core_hash_i slice k is written into buffer slot k and captured[k] sets.
  - A result arriving in the same cycle the core's start is accepted is not taken; it is taken the next cycle.
  - core_v_i on unmasked or already-captured cores is ignored (yumi=0).
- WAIT → SEND when captured (including same-cycle captures) == mask. v_o rises the cycle after the final capture.
- SEND:
  - Beat count B = N*HASH_W/DATA_W; beat counter runs 0..B-1.
  - Order is slot 0 first, each hash most-significant DATA_W first; beat j = buffer bits [N*HASH_W-1 - j*DATA_W -: DATA_W].
  - v_o=1. data_o and last_o stay stable while v_o & ~yumi_i.
  - last_o=1 only on beat B-1. On yumi_i the counter increments.
  - On yumi_i with last_o, go to IDLE. job_ready_o=1 the next cycle, so there is 1 idle cycle between jobs.
- Output ordering:
  - Output order depends only on slot index, never on completion order.
  - No output beat is emitted before all N captures.
- In non-SEND states v_o, last_o = 0 and data_o = 0. core_v_o = 0 outside ISSUE. core_yumi_o = 0 outside ISSUE/WAIT.
- Counters are sized for the maximum B = NUM_CORES*HASH_W/DATA_W and never wrap within a job.

Test Plan:
- Defaults, job_chunks_i=0, core0 ready immediately, result 0x0123..EF repeated:
  - core_v_o=4'b0001 for 1 cycle.
  - 4 beats, MS word first, last_o on beat 3.
  - No yumi to cores 1-3.
- job_chunks_i=3, cores accept in order 2,0,3,1 on consecutive cycles:
  - each core_v_o bit drops the cycle after its own ready.
  - state leaves ISSUE only after core1 accepts.
- job_chunks_i=3, results arrive in order 3,1,0,2 with distinct patterns:
  - v_o rises 1 cycle after core2's yumi.
  - 16 beats in slot order 0,1,2,3; last_o only on beat 15.
- SEND with yumi_i toggled 1/0 every other cycle:
  - data_o and last_o hold during stalls.
  - exactly 8 beats for job_chunks_i=1.
- Spurious core_v_i[3]=1 during a job_chunks_i=1 job:
  - core_yumi_o[3] stays 0, and core3 data never appears on data_o.
- reset_ni pulsed low mid-SEND after beat 2:
  - all outputs 0 immediately.
  - job_ready_o=1 one edge after release.
  - a new job then completes normally.

Source files
------------

// File: rtl/kda_dispatch.sv
// Job dispatcher/collector: fans one key-derivation job out to 1..NUM_CORES PBKDF2
// cores, gathers results in any order and streams the derived key out MS-word first.
module kda_dispatch #(
   parameter int NUM_CORES = 4,
   parameter int HASH_W    = 256,
   parameter int DATA_W    = 64,
   parameter int CW        = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
   input  logic                        clk_i,
   input  logic                        reset_ni,
   input  logic [CW-1:0]               job_chunks_i,
   input  logic                        job_v_i,
   output logic                        job_ready_o,
   output logic [NUM_CORES-1:0]        core_v_o,
   input  logic [NUM_CORES-1:0]        core_ready_i,
   input  logic [NUM_CORES-1:0]        core_v_i,
   input  logic [NUM_CORES*HASH_W-1:0] core_hash_i,
   output logic [NUM_CORES-1:0]        core_yumi_o,
   output logic [DATA_W-1:0]           data_o,
   output logic                        v_o,
   output logic                        last_o,
   input  logic                        yumi_i,
   output logic                        busy_o
);
   localparam int BPH = HASH_W / DATA_W;
   localparam int SW  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
   localparam int WW  = (BPH > 1) ? $clog2(BPH) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, SEND} state_t;

   state_t               state_reg, state_next;
   logic [NUM_CORES-1:0] mask_reg, mask_next;
   logic [NUM_CORES-1:0] issued_reg, issued_next;
   logic [NUM_CORES-1:0] captured_reg, captured_next;
   logic [SW-1:0]        slot_reg, slot_next;
   logic [SW-1:0]        last_slot_reg, last_slot_next;
   logic [WW-1:0]        word_reg, word_next;
   logic                 ready_en_reg;
   logic [HASH_W-1:0]    hash_buf_reg [NUM_CORES];

   logic [CW-1:0]        chunk_sat;
   logic [NUM_CORES-1:0] job_mask;
   logic [NUM_CORES-1:0] accepted;
   logic                 word_last;

   // Chunk requests beyond the attached cores saturate to all cores.
   assign chunk_sat = (int'(job_chunks_i) > NUM_CORES - 1) ? CW'(NUM_CORES - 1) : job_chunks_i;

   generate
      for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_slot
         assign job_mask[gi] = (int'(chunk_sat) >= gi);

         always_ff @(posedge clk_i or negedge reset_ni) begin
            if (!reset_ni) begin
               hash_buf_reg[gi] <= '0;
            end else if (core_yumi_o[gi]) begin
               hash_buf_reg[gi] <= core_hash_i[gi*HASH_W +: HASH_W];
            end
         end
      end
   endgenerate

   // ready_en_reg keeps job_ready_o low until the first edge after reset release.
   assign job_ready_o = ready_en_reg & (state_reg == IDLE);
   assign busy_o      = (state_reg != IDLE);
   assign core_v_o    = (state_reg == ISSUE) ? (mask_reg & ~issued_reg) : '0;
   assign accepted    = core_v_o & core_ready_i;
   assign core_yumi_o = (state_reg == ISSUE || state_reg == WAIT)
                        ? (core_v_i & mask_reg & issued_reg & ~captured_reg) : '0;
   assign word_last   = (word_reg == WW'(BPH - 1));
   assign v_o         = (state_reg == SEND);
   assign last_o      = v_o & word_last & (slot_reg == last_slot_reg);

   // Slot 0 leads the stream; within a slot the most-significant word goes first.
   always_comb begin
      data_o = '0;
      if (state_reg == SEND) begin
         data_o = hash_buf_reg[slot_reg][(BPH - 1 - int'(word_reg))*DATA_W +: DATA_W];
      end
   end

   always_comb begin
      state_next     = state_reg;
      mask_next      = mask_reg;
      issued_next    = issued_reg | accepted;
      captured_next  = captured_reg | core_yumi_o;
      slot_next      = slot_reg;
      last_slot_next = last_slot_reg;
      word_next      = word_reg;
      case (state_reg)
         IDLE: begin
            if (job_ready_o && job_v_i) begin
               state_next     = ISSUE;
               mask_next      = job_mask;
               issued_next    = '0;
               captured_next  = '0;
               slot_next      = '0;
               word_next      = '0;
               last_slot_next = SW'(chunk_sat);
            end
         end
         ISSUE: begin
            if (issued_next == mask_reg) state_next = WAIT;
         end
         WAIT: begin
            if (captured_next == mask_reg) state_next = SEND;
         end
         SEND: begin
            if (yumi_i) begin
               if (last_o) begin
                  state_next = IDLE;
               end else if (word_last) begin
                  word_next = '0;
                  slot_next = slot_reg + SW'(1);
               end else begin
                  word_next = word_reg + WW'(1);
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_reg     <= IDLE;
         mask_reg      <= '0;
         issued_reg    <= '0;
         captured_reg  <= '0;
         slot_reg      <= '0;
         last_slot_reg <= '0;
         word_reg      <= '0;
         ready_en_reg  <= 1'b0;
      end else begin
         state_reg     <= state_next;
         mask_reg      <= mask_next;
         issued_reg    <= issued_next;
         captured_reg  <= captured_next;
         slot_reg      <= slot_next;
         last_slot_reg <= last_slot_next;
         word_reg      <= word_next;
         ready_en_reg  <= 1'b1;
      end
   end
endmodule
